// File: rtl/leds_controller_if.sv
// Command/LED bus between the command decoder and the LED driver.
//   cmd  : 3-bit LED command pattern (bit i requests LED i)
//   leds : 3-bit registered LED drive (bit i = LED i, 1 = on)
// The master modport is used by the command source.
// The slave modport is used by leds_controller.
interface leds_controller_if;
    logic [2:0] cmd;
    logic [2:0] leds;

    modport master (output cmd, input leds);
    modport slave  (input cmd, output leds);
endinterface

// File: rtl/leds_controller.sv
// Three-LED driver.
//
// In AUTO mode the block rotates a one-hot pattern: 001 -> 010 -> 100 -> 001.
// Each LED stays lit for AUTO_PERIOD cycles.
//
// A nonzero change on the command bus is a command event. It latches the
// commanded pattern onto the LEDs for MANUAL_HOLD cycles. After that window
// the block returns to AUTO mode, starting again from 001.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high reset
//   bus_io : slave side of leds_controller_if (cmd in, leds out)
module leds_controller #(
    parameter int unsigned AUTO_PERIOD = 5,
    parameter int unsigned MANUAL_HOLD = 20,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    leds_controller_if.slave    bus_io
);

    typedef enum logic {StAuto, StManual} mode_e;

    localparam logic [CNT_W-1:0] AutoLast = CNT_W'(AUTO_PERIOD - 1);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MANUAL_HOLD - 1);

    mode_e            mode_q, mode_d;
    logic [2:0]       leds_q, leds_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [CNT_W-1:0] auto_cnt_q, auto_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             cmd_event;

    // A change to 000 is deliberately not an event.
    assign cmd_event = (bus_io.cmd != cmd_q) && (bus_io.cmd != 3'b000);

    always_comb begin
        mode_d     = mode_q;
        leds_d     = leds_q;
        cmd_d      = bus_io.cmd;
        auto_cnt_d = auto_cnt_q;
        hold_cnt_d = hold_cnt_q;

        if (cmd_event) begin
            // An event wins even on the edge where the hold would expire.
            mode_d     = StManual;
            leds_d     = bus_io.cmd;
            auto_cnt_d = '0;
            hold_cnt_d = '0;
        end else begin
            unique case (mode_q)
                StManual: begin
                    if (hold_cnt_q == HoldLast) begin
                        mode_d     = StAuto;
                        leds_d     = 3'b001;
                        auto_cnt_d = '0;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end
                StAuto: begin
                    if (auto_cnt_q == AutoLast) begin
                        auto_cnt_d = '0;
                        leds_d     = {leds_q[1:0], leds_q[2]};
                    end else begin
                        auto_cnt_d = auto_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    mode_d = StAuto;
                    leds_d = 3'b001;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= StAuto;
            leds_q     <= 3'b001;
            cmd_q      <= 3'b000;
            auto_cnt_q <= '0;
            hold_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            leds_q     <= leds_d;
            cmd_q      <= cmd_d;
            auto_cnt_q <= auto_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign bus_io.leds = leds_q;

endmodule

// File: tb/tb_leds_controller.sv
// Self-checking bench for leds_controller.
//
// The stimulus process drives cmd/reset for each edge. It asks a timeline
// model what leds must show after that edge and queues the answer.
// The model tracks when the current mode began and derives the LED pattern
// from elapsed time.
//
// The monitor counts edges. At each falling edge it pops the matching
// expectation and compares it with the DUT output.
module tb_leds_controller;

    localparam int AutoPeriod = 5;
    localparam int ManualHold = 20;

    typedef struct {
        int         cyc;
        logic [2:0] leds;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   stim_cyc = 0;

    // Reference model state
    bit         m_manual;
    logic [2:0] m_pattern;
    logic [2:0] m_prev;
    int         m_man_start;
    int         m_auto_start;

    leds_controller_if bus ();

    leds_controller #(
        .AUTO_PERIOD (AutoPeriod),
        .MANUAL_HOLD (ManualHold),
        .CNT_W       (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Returns the LED pattern expected after edge k with the given inputs.
    function automatic logic [2:0] model_step(input bit rst, input logic [2:0] c, input int k);
        logic [2:0] one;
        one = 3'b001;
        if (rst) begin
            m_prev       = 3'b000;
            m_manual     = 1'b0;
            m_auto_start = k;
        end else begin
            if (c != m_prev && c != 3'b000) begin
                m_manual    = 1'b1;
                m_man_start = k;
                m_pattern   = c;
            end else if (m_manual && (k - m_man_start) >= ManualHold) begin
                m_manual     = 1'b0;
                m_auto_start = k;
            end
            m_prev = c;
        end
        if (m_manual) return m_pattern;
        return one << (((k - m_auto_start) / AutoPeriod) % 3);
    endfunction

    task automatic run(input bit rst, input logic [2:0] c, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            reset   = rst;
            bus.cmd = c;
            e.cyc   = stim_cyc + 1;
            e.leds  = model_step(rst, c, stim_cyc + 1);
            exp_q.push_back(e);
            @(posedge clk);
            stim_cyc++;
            #1;
        end
    endtask

    // Monitor: compare once per edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_cnt++;
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_check cyc %0d expected %b not compared", e.cyc, e.leds);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.leds !== e.leds) begin
                    errors++;
                    $display("FAIL leds cyc %0d got %b expected %b", edge_cnt, bus.leds, e.leds);
                end
            end
        end
    end

    initial begin
        logic [2:0] c;
        bit         r;
        reset   = 1'b1;
        bus.cmd = 3'b000;

        // Plain rotation after reset
        run(1, 3'b000, 1);
        run(0, 3'b000, 20);
        // Reset, wait, then command 001 held, then a new event, then 100 held long
        run(1, 3'b000, 1);
        run(0, 3'b000, 5);
        run(0, 3'b001, 30);
        run(0, 3'b010, 30);
        run(0, 3'b100, 90);
        // Multi-hot, then 000 mid-hold has no effect
        run(0, 3'b011, 8);
        run(0, 3'b000, 20);
        // Reset mid-MANUAL with cmd held nonzero
        run(0, 3'b010, 5);
        run(1, 3'b010, 2);
        run(0, 3'b010, 30);
        // Event exactly on the expiry edge
        run(0, 3'b100, ManualHold);
        run(0, 3'b001, 25);

        // Randomized traffic
        c = 3'b000;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(7) == 0) c = 3'($urandom_range(7));
            r = ($urandom_range(63) == 0);
            run(r, c, 1);
        end

        // Let the monitor drain, bounded by a cycle budget
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain remaining %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
